srl_seq: RTL and testbench
==========================

Name: srl_seq

Overview:
Iterative shift-right unit, the reverse-direction companion to the catalog's shift-left element. It shifts one bit position per enabled clock, with a start/busy/done handshake. Logical or arithmetic fill is selected per operation. It sits in the catalog as the area-cheap right shifter for the ALU datapath.

Parameters:
N, 8, data width in bits
AMT_N, 3, width of shift-amount field (max shift 2^AMT_N-1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
en  input  1  clock enable; low freezes all state
start  input  1  request; sampled only in IDLE with en=1
d  input  N  operand, latched on accepted start
amt  input  AMT_N  shift amount, latched on accepted start
arith  input  1  1=arithmetic (sign fill), 0=logical (zero fill); latched on start
busy  output  1  high in SHIFT and DONE states
done  output  1  high for exactly the one enabled cycle in DONE
out  output  N  result register; holds last result until next completion

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, cnt=0, out=0, busy=0, done=0. Takes effect immediately, including mid-operation. Any in-flight result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, en=1, start=1 at edge k:
  - shreg<=d, cnt<=amt, fill mode<=arith.
  - If amt==0: next state DONE and out<=d.
  - Otherwise next state SHIFT.
- IDLE, start=0: remain in IDLE; out holds its value.
- SHIFT, each enabled edge:
  - shreg<={fill, shreg[N-1:1]}. fill = shreg[N-1] if arithmetic, else 0. The sign is the latched operand MSB, which propagates unchanged.
  - cnt<=cnt-1.
  - When cnt==1, next state DONE and out<=shifted value, so out is valid in the same cycle done rises.
- DONE: done=1, busy=1. The next enabled edge returns to IDLE.
  - start asserted during DONE is ignored; a new op needs start in IDLE, so back-to-back ops are 1 idle cycle apart.
- Latency: done is high during the cycle after edge k+amt (amt=0 gives the cycle after edge k).
- en=0: no register changes in any state; done stays high if frozen in DONE. Latency counts enabled edges only.
- start while busy (SHIFT/DONE) is ignored; d/amt/arith changes mid-op do not affect the result.
- Width rules: cnt is AMT_N bits and never underflows (amt==0 bypasses SHIFT). Shift by the maximum amount (2^AMT_N-1) is legal. Logical shift by N-1 leaves at most bit0 set.

Decomposition:
- Shared package srl_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} srl_state_t
  - localparams for the fill modes.
- One combinational sub-module, srl_step (N-bit, 1-position right shift with fill input). This keeps the datapath reusable for a future rotate element.
- FSM and counter live in srl_seq.

Test Plan:
- d=8'b1011_0100, amt=3, arith=0, start 1 cycle, en=1 → busy next cycle; done in the cycle after edge k+3; out=8'b0001_0110.
- Same d/amt, arith=1 → out=8'b1111_0110; done timing identical.
- d=8'hA5, amt=0 → done in the cycle after edge k; out=8'hA5; busy high 1 cycle only.
- d=8'h80, amt=7, arith=1 → out=8'hFF. Then arith=0 → out=8'h01, done after 7 enabled edges.
- Stall: d=8'hF0, amt=4, arith=0, en=0 for 3 cycles mid-SHIFT → done 3 cycles later than baseline; out=8'h0F. Also, start pulsed with d=8'h00 during SHIFT → ignored, result unchanged.
- Reset: rst low for 1 cycle during SHIFT of d=8'hFF, amt=5 → out=0, busy=0, done=0 immediately. A fresh op after release (d=8'h40, amt=2, logical) yields 8'h10.

Source files
------------

// File: rtl/srl_pkg.sv
// Shared types for the iterative right shifter.
// FSM states and fill-mode encodings.
package srl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } srl_state_t;

  localparam logic FILL_LOGIC = 1'b0;
  localparam logic FILL_ARITH = 1'b1;

endpackage

// File: rtl/srl_step.sv
// One-position right shift with an explicit fill bit.
// Pure combinational datapath slice.
module srl_step
  import srl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic         fill,
  output logic [N-1:0] y
);

  // shift right by one, inserting fill at the MSB
  always_comb begin
    y = {fill, a[N-1:1]};
  end

endmodule

// File: rtl/srl_seq.sv
// Iterative right shifter, one bit per enabled clock.
// start/busy/done handshake; logical or arithmetic fill.
module srl_seq
  import srl_pkg::*;
#(
  parameter int N     = 8,
  parameter int AMT_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [N-1:0]     d,
  input  logic [AMT_N-1:0] amt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     out
);

  srl_state_t       state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [AMT_N-1:0] cnt_q, cnt_d;
  logic             arith_q, arith_d;
  logic [N-1:0]     out_q, out_d;

  logic             fill;
  logic [N-1:0]     step_y;

  // sign fill takes the MSB, which the shift itself preserves
  always_comb begin
    fill = 1'b0;
    if (arith_q == FILL_ARITH) begin
      fill = shreg_q[N-1];
    end
  end

  srl_step #(
    .N(N)
  ) u_step (
    .a   (shreg_q),
    .fill(fill),
    .y   (step_y)
  );

  // next-state, counter and result update
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    out_d   = out_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg_d = d;
            cnt_d   = amt;
            arith_d = arith;
            if (amt == '0) begin
              state_d = DONE;
              out_d   = d;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          shreg_d = step_y;
          cnt_d   = cnt_q - AMT_N'(1);
          if (cnt_q == AMT_N'(1)) begin
            state_d = DONE;
            out_d   = step_y;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      arith_q <= FILL_LOGIC;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      out_q   <= out_d;
    end
  end

  // status decoded straight from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    out  = out_q;
  end

endmodule

// File: tb/tb_srl_seq.sv
// Directed bench for srl_seq with a result scoreboard.
// Checks timing, fill modes, stalls and async reset.
module tb_srl_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic [7:0] d;
  logic [2:0] amt;
  logic       arith;
  logic       busy;
  logic       done;
  logic [7:0] out;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb_q[$];

  srl_seq #(
    .N    (8),
    .AMT_N(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .d    (d),
    .amt  (amt),
    .arith(arith),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // compare out against the oldest queued result
  task automatic sb_pop(input string tag);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_out"}, 32'(out), 32'(e));
    end
  endtask

  // wait for done, counting enabled edges
  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic run_op(
    input string      tag,
    input logic [7:0] dv,
    input logic [2:0] av,
    input logic       ar,
    input logic [7:0] ev
  );
    int c;
    d     = dv;
    amt   = av;
    arith = ar;
    start = 1'b1;
    sb_q.push_back(ev);
    tick();
    start = 1'b0;
    d     = ~dv;
    amt   = 3'd1;
    arith = ~ar;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(c);
    chk({tag, "_lat"}, c, 32'(av));
    chk({tag, "_done"}, 32'(done), 32'd1);
    sb_pop(tag);
    // start during DONE must be ignored
    start = 1'b1;
    d     = 8'h5A;
    amt   = 3'd0;
    tick();
    start = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_dn0"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(out), 32'(ev));
  endtask

  initial begin
    int         c;
    int         cyc;
    logic [7:0] dv;
    logic [2:0] av;
    logic       ar;
    logic [7:0] ev;

    rst   = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    d     = '0;
    amt   = '0;
    arith = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    rst = 1'b1;
    tick();

    run_op("lsr3", 8'b1011_0100, 3'd3,
           1'b0, 8'b0001_0110);
    run_op("asr3", 8'b1011_0100, 3'd3,
           1'b1, 8'b1111_0110);

    // amt=0: done right after edge k, one busy cycle
    d     = 8'hA5;
    amt   = 3'd0;
    arith = 1'b0;
    start = 1'b1;
    sb_q.push_back(8'hA5);
    tick();
    start = 1'b0;
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd1);
    sb_pop("z");
    tick();
    chk("z_busy2", 32'(busy), 32'd0);

    run_op("asr7", 8'h80, 3'd7, 1'b1, 8'hFF);
    run_op("lsr7", 8'h80, 3'd7, 1'b0, 8'h01);

    // stall mid-SHIFT plus ignored start
    d     = 8'hF0;
    amt   = 3'd4;
    arith = 1'b0;
    start = 1'b1;
    sb_q.push_back(8'h0F);
    tick();
    start = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_frz_busy", 32'(busy), 32'd1);
      chk("st_frz_done", 32'(done), 32'd0);
    end
    en    = 1'b1;
    d     = 8'h00;
    amt   = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    chk("st_lat", c + 2, 32'd4);
    sb_pop("st");
    // frozen in DONE keeps done high
    en = 1'b0;
    tick();
    tick();
    chk("st_dhold", 32'(done), 32'd1);
    en = 1'b1;
    tick();
    chk("st_idle", 32'(busy), 32'd0);

    // async reset mid-SHIFT discards the op
    d     = 8'hFF;
    amt   = 3'd5;
    arith = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("r_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("r_out", 32'(out), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    run_op("post", 8'h40, 3'd2, 1'b0, 8'h10);

    // a few random ops against a shift-operator model
    for (int i = 0; i < 6; i++) begin
      dv = 8'($urandom);
      av = 3'($urandom_range(0, 7));
      ar = 1'($urandom);
      if (ar) ev = $signed(dv) >>> av;
      else    ev = dv >> av;
      run_op("rnd", dv, av, ar, ev);
    end

    cyc = sb_q.size();
    chk("sb_drain", cyc, 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
